div_arbiter: RTL and testbench



---
 rtl/div_arbiter.sv | 139 +++++++++++++
 tb/tb_div_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one combinational divider between two requesters.
// Operands are registered onto div_a/div_b, held SETTLE cycles, then q/r are returned.
module div_arbiter #(
    parameter int WIDTH  = 6,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp0_q,
    output logic [WIDTH-1:0] rsp0_r,
    output logic [WIDTH-1:0] rsp1_q,
    output logic [WIDTH-1:0] rsp1_r,
    output logic             rsp0_dz,
    output logic             rsp1_dz,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r
);
    // state | meaning
    // IDLE  | arbitrate and accept at most one request
    // ISSUE | operands held on div_a/div_b, settle counter running down
    // RESP  | owner's response valid, waiting for its rsp ready
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    logic [1:0]       r_state;
    logic [3:0]       r_cnt;
    logic             r_owner;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_div_a, r_div_b;
    logic [WIDTH-1:0] r_q0, r_r0, r_q1, r_r1;
    logic             r_dz0, r_dz1;

    logic             w_grant;
    logic             w_accept;
    logic             w_rsp_ready;
    logic [WIDTH-1:0] w_a, w_b;

    // Grant index: lone requester wins, contention goes to the one not served last.
    always_comb begin
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = req1_valid;
        end
    end

    assign req0_ready  = (r_state == S_IDLE) && req0_valid && !w_grant;
    assign req1_ready  = (r_state == S_IDLE) && req1_valid && w_grant;
    assign w_accept    = req0_ready || req1_ready;
    assign w_a         = w_grant ? req1_a : req0_a;
    assign w_b         = w_grant ? req1_b : req0_b;
    assign w_rsp_ready = r_owner ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_div_a      <= '0;
            r_div_b      <= '0;
            r_q0         <= '0;
            r_r0         <= '0;
            r_dz0        <= 1'b0;
            r_q1         <= '0;
            r_r1         <= '0;
            r_dz1        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_div_a      <= w_a;
                        r_div_b      <= w_b;
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        if (w_b != '0) begin
                            r_state <= S_ISSUE;
                            r_cnt   <= CNT_LOAD;
                        end else begin
                            // Divide by zero never touches the divider.
                            r_state <= S_RESP;
                            if (w_grant) begin
                                {r_q1, r_r1, r_dz1} <= {{WIDTH{1'b1}}, w_a, 1'b1};
                            end else begin
                                {r_q0, r_r0, r_dz0} <= {{WIDTH{1'b1}}, w_a, 1'b1};
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                        if (r_owner) begin
                            {r_q1, r_r1, r_dz1} <= {div_q, div_r, 1'b0};
                        end else begin
                            {r_q0, r_r0, r_dz0} <= {div_q, div_r, 1'b0};
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (w_rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp0_valid = (r_state == S_RESP) && !r_owner;
    assign rsp1_valid = (r_state == S_RESP) && r_owner;
    assign rsp0_q     = r_q0;
    assign rsp0_r     = r_r0;
    assign rsp0_dz    = r_dz0;
    assign rsp1_q     = r_q1;
    assign rsp1_r     = r_r1;
    assign rsp1_dz    = r_dz1;
    assign div_a      = r_div_a;
    assign div_b      = r_div_b;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: a transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_div_arbiter;
    localparam int WIDTH  = 6;
    localparam int SETTLE = 2;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready, rsp1_ready;
    logic [WIDTH-1:0] rsp0_q, rsp0_r, rsp1_q, rsp1_r;
    logic             rsp0_dz, rsp1_dz;
    logic [WIDTH-1:0] div_a, div_b, div_q, div_r;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    div_arbiter #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp0_q(rsp0_q), .rsp0_r(rsp0_r), .rsp1_q(rsp1_q), .rsp1_r(rsp1_r),
        .rsp0_dz(rsp0_dz), .rsp1_dz(rsp1_dz),
        .div_a(div_a), .div_b(div_b), .div_q(div_q), .div_r(div_r)
    );

    // Stand-in for div_top; returns zeros for b=0 so a stray sample is visible.
    assign div_q = (div_b == '0) ? '0 : div_a / div_b;
    assign div_r = (div_b == '0) ? '0 : div_a % div_b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one in-flight transaction, response due SETTLE+1 cycles after
    // accept (or 1 cycle for b=0), values from plain arithmetic.
    logic             m_started = 1'b0;
    logic             m_busy = 1'b0, m_owner = 1'b0, m_last = 1'b1;
    int               m_delay = 0;
    logic [WIDTH-1:0] m_da = '0, m_db = '0, m_pq = '0, m_pr = '0;
    logic [WIDTH-1:0] m_q0 = '0, m_r0 = '0, m_q1 = '0, m_r1 = '0;
    logic             m_dz0 = 1'b0, m_dz1 = 1'b0;
    logic             e_rdy0, e_rdy1, e_v0, e_v1, t_g;
    logic [WIDTH-1:0] t_a, t_b;

    always @(negedge clk) begin
        e_rdy0 = !m_busy && req0_valid && (!req1_valid || m_last);
        e_rdy1 = !m_busy && req1_valid && (!req0_valid || !m_last);
        e_v0   = m_busy && (m_delay == 0) && !m_owner;
        e_v1   = m_busy && (m_delay == 0) && m_owner;
        if (m_started) begin
            chk("req0_ready", req0_ready, e_rdy0);
            chk("req1_ready", req1_ready, e_rdy1);
            chk("rsp0_valid", rsp0_valid, e_v0);
            chk("rsp1_valid", rsp1_valid, e_v1);
            chk("rsp0_q", rsp0_q, m_q0);
            chk("rsp0_r", rsp0_r, m_r0);
            chk("rsp0_dz", rsp0_dz, m_dz0);
            chk("rsp1_q", rsp1_q, m_q1);
            chk("rsp1_r", rsp1_r, m_r1);
            chk("rsp1_dz", rsp1_dz, m_dz1);
            chk("div_a", div_a, m_da);
            chk("div_b", div_b, m_db);
        end
        if (!rst_n) begin
            m_started = 1'b1;
            m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_delay = 0;
            m_da = '0; m_db = '0;
            m_q0 = '0; m_r0 = '0; m_dz0 = 1'b0;
            m_q1 = '0; m_r1 = '0; m_dz1 = 1'b0;
        end else if (!m_busy) begin
            if (e_rdy0 || e_rdy1) begin
                t_g = e_rdy1;
                t_a = t_g ? req1_a : req0_a;
                t_b = t_g ? req1_b : req0_b;
                m_da = t_a; m_db = t_b; m_owner = t_g; m_last = t_g; m_busy = 1'b1;
                if (t_b == '0) begin
                    m_delay = 0;
                    if (t_g) begin m_q1 = '1; m_r1 = t_a; m_dz1 = 1'b1; end
                    else     begin m_q0 = '1; m_r0 = t_a; m_dz0 = 1'b1; end
                end else begin
                    m_delay = SETTLE;
                    m_pq = t_a / t_b;
                    m_pr = t_a % t_b;
                end
            end
        end else if (m_delay > 0) begin
            m_delay--;
            if (m_delay == 0) begin
                if (m_owner) begin m_q1 = m_pq; m_r1 = m_pr; m_dz1 = 1'b0; end
                else         begin m_q0 = m_pq; m_r0 = m_pr; m_dz0 = 1'b0; end
            end
        end else if (m_owner ? rsp1_ready : rsp0_ready) begin
            m_busy = 1'b0;
        end
    end

    // Observation log for the directed scenarios.
    int               gq[$];
    int               acc0 = 0, acc1 = 0, hs0 = 0, hs1 = 0;
    logic [WIDTH-1:0] h_q0 = '0, h_r0 = '0, h_q1 = '0, h_r1 = '0;

    always @(negedge clk) begin
        if (req0_valid && req0_ready) begin gq.push_back(0); acc0 <= cyc; end
        if (req1_valid && req1_ready) begin gq.push_back(1); acc1 <= cyc; end
        if (rsp0_valid && rsp0_ready) begin h_q0 <= rsp0_q; h_r0 <= rsp0_r; hs0 <= hs0 + 1; end
        if (rsp1_valid && rsp1_ready) begin h_q1 <= rsp1_q; h_r1 <= rsp1_r; hs1 <= hs1 + 1; end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    // Present one request and return #1 after the accepting edge.
    task automatic do_req(input int who, input int a, input int b);
        bit ok;
        ok = 1'b0;
        if (who == 0) begin req0_a = WIDTH'(a); req0_b = WIDTH'(b); req0_valid = 1'b1; end
        else          begin req1_a = WIDTH'(a); req1_b = WIDTH'(b); req1_valid = 1'b1; end
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = (who == 0) ? (req0_ready === 1'b1) : (req1_ready === 1'b1);
        end
        step(1);
        if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout req%0d: got no ready expected ready within 100 cycles", who);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, seen;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        do_reset();
        chk("reset_rsp0_valid", rsp0_valid, 0);
        chk("reset_rsp1_valid", rsp1_valid, 0);
        chk("reset_div_a", div_a, 0);
        chk("reset_rsp1_q", rsp1_q, 0);

        // Single request: response in T+3 for one cycle.
        do_req(0, 45, 7);
        chk("s1_valid_t1", rsp0_valid, 0);
        step(1);
        chk("s1_valid_t2", rsp0_valid, 0);
        step(1);
        chk("s1_valid_t3", rsp0_valid, 1);
        chk("s1_q", rsp0_q, 6);
        chk("s1_r", rsp0_r, 3);
        chk("s1_dz", rsp0_dz, 0);
        chk("s1_rsp1_valid", rsp1_valid, 0);
        step(1);
        chk("s1_valid_t4", rsp0_valid, 0);

        // Contention after reset: req0 first, req1 accepted right after rsp0 completes.
        do_reset();
        fork
            do_req(0, 63, 8);
            do_req(1, 20, 3);
        join
        step(6);
        chk("s2_gap", acc1 - acc0, 4);
        chk("s2_q0", h_q0, 7);
        chk("s2_r0", h_r0, 7);
        chk("s2_q1", h_q1, 6);
        chk("s2_r1", h_r1, 2);

        // Fairness under continuous contention.
        do_reset();
        base = gq.size();
        fork
            begin for (int i = 0; i < 4; i++) do_req(0, 10 + i, 3); end
            begin for (int j = 0; j < 4; j++) do_req(1, 30 + j, 5); end
        join
        step(6);
        chk("s3_grants", gq.size() - base, 8);
        for (int k = 0; k < 8; k++) chk("s3_order", gq[base + k], k % 2);

        // Zero divisor: immediate response.
        do_reset();
        do_req(1, 13, 0);
        chk("s4_valid", rsp1_valid, 1);
        chk("s4_q", rsp1_q, 63);
        chk("s4_r", rsp1_r, 13);
        chk("s4_dz", rsp1_dz, 1);
        chk("s4_rsp0_valid", rsp0_valid, 0);

        // Backpressure on rsp0 while req1 waits.
        do_reset();
        rsp0_ready = 1'b0;
        do_req(0, 45, 7);
        fork
            do_req(1, 9, 2);
            begin
                step(2);
                for (int k = 0; k < 5; k++) begin
                    chk("s5_valid", rsp0_valid, 1);
                    chk("s5_q", rsp0_q, 6);
                    chk("s5_r", rsp0_r, 3);
                    chk("s5_req1_ready", req1_ready, 0);
                    step(1);
                end
                rsp0_ready = 1'b1;
            end
        join
        step(6);
        chk("s5_q1", h_q1, 4);
        chk("s5_r1", h_r1, 1);

        // Reset mid-ISSUE discards the operation and restores last_grant.
        do_reset();
        do_req(1, 45, 7);
        seen = hs1;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("s6_rsp1_valid", rsp1_valid, 0);
        chk("s6_div_a", div_a, 0);
        chk("s6_div_b", div_b, 0);
        chk("s6_rsp1_q", rsp1_q, 0);
        step(5);
        chk("s6_no_rsp", hs1 - seen, 0);
        fork
            do_req(0, 50, 5);
            do_req(1, 7, 7);
        join
        step(6);
        chk("s6_gap", acc1 - acc0, 4);
        chk("s6_q0", h_q0, 10);
        chk("s6_q1", h_q1, 1);

        // Exhaustive sweep on alternating requesters; the model checks every result.
        do_reset();
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 64; b++) begin
                do_req((a * 64 + b) % 2, a, b);
            end
        end
        step(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
